jzjpcc_muldiv_sequencer: RTL and testbench

Multi-cycle controller for the RV32M multiply/divide operations in the execute stage. It accepts an M-extension op alongside the ALU path, stalls the front of the pipeline while an iterative shift-add/restoring-divide datapath runs, and presents a registered 32-bit result for the execute-to-memory register. Divide-by-zero and signed overflow are resolved in one cycle, without iterating.

---
 rtl/jzjpcc_pkg.sv | 38 +++
 rtl/jzjpcc_muldiv_datapath.sv | 92 +++++++++
 rtl/jzjpcc_muldiv_sequencer.sv | 130 +++++++++++++
 tb/tb_jzjpcc_muldiv_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer and datapath.
package jzjpcc_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERATIONS     = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT     = 32'hFFFFFFFF;
    localparam logic [31:0] DIV_OVERFLOW_QUOTIENT = 32'h80000000;

    function automatic logic is_div_op(input muldiv_op_t op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    // MUL is treated as signed: its low word is identical either way.
    function automatic logic signed_a_op(input muldiv_op_t op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic signed_b_op(input muldiv_op_t op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/jzjpcc_muldiv_datapath.sv
// Iterative shift-add multiply / restoring divide on operand magnitudes, with sign fix-up.
module jzjpcc_muldiv_datapath
    import jzjpcc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  muldiv_op_t  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] step_result
);

    // acc holds {partial product} for multiply, {remainder, quotient} for divide.
    logic [63:0] acc_q;
    logic [31:0] divisor_q;
    muldiv_op_t  op_q;
    logic        a_neg_q;
    logic        b_neg_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_top;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step_acc;
    logic [63:0] neg_acc;
    logic [31:0] neg_rem;

    always_comb begin
        a_neg = signed_a_op(op) & operand_a[31];
        b_neg = signed_b_op(op) & operand_b[31];
        a_mag = a_neg ? (32'd0 - operand_a) : operand_a;
        b_mag = b_neg ? (32'd0 - operand_b) : operand_b;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? divisor_q : 32'd0)};
        mul_next = {mul_sum, acc_q[31:1]};

        div_top  = acc_q[63:31];
        div_ge   = div_top >= {1'b0, divisor_q};
        div_diff = div_top[31:0] - divisor_q;
        div_next = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                          : {div_top[31:0], acc_q[30:0], 1'b0};

        step_acc = is_div_op(op_q) ? div_next : mul_next;
        neg_acc  = 64'd0 - step_acc;
        neg_rem  = 32'd0 - step_acc[63:32];
    end

    // Result as it will stand once the current step has been applied.
    always_comb begin
        step_result = '0;
        unique case (op_q)
            OpMul:                     step_result = (a_neg_q ^ b_neg_q) ? neg_acc[31:0]
                                                                         : step_acc[31:0];
            OpMulh, OpMulhsu, OpMulhu: step_result = (a_neg_q ^ b_neg_q) ? neg_acc[63:32]
                                                                         : step_acc[63:32];
            OpDiv, OpDivu:             step_result = (a_neg_q ^ b_neg_q) ? neg_acc[31:0]
                                                                         : step_acc[31:0];
            OpRem, OpRemu:             step_result = a_neg_q ? neg_rem : step_acc[63:32];
            default:                   step_result = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            divisor_q <= '0;
            op_q      <= OpMul;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
        end else if (load) begin
            acc_q     <= {32'd0, a_mag};
            divisor_q <= b_mag;
            op_q      <= op;
            a_neg_q   <= a_neg;
            b_neg_q   <= b_neg;
        end else if (step) begin
            acc_q     <= step_acc;
        end
    end

endmodule

// File: rtl/jzjpcc_muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, iteration counter, pipeline stall and special-case resolve.
// Optional JZJPCC_FAST_MUL_EN resolves all multiplies in one cycle with a hardware multiplier.
module jzjpcc_muldiv_sequencer
    import jzjpcc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        flush,
    output logic        executeStall,
    output logic [31:0] result,
    output logic        resultValid
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERATIONS - 1);

    muldiv_state_t state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   result_q, result_d;
    logic          load;
    logic          step;
    logic [31:0]   step_result;
    muldiv_op_t    op_e;

    logic          special;
    logic [31:0]   special_result;
    logic          fast_mul;
    logic [31:0]   fast_result;

    assign op_e = muldiv_op_t'(op);

`ifdef JZJPCC_FAST_MUL_EN
    logic signed [32:0] fast_a;
    logic signed [32:0] fast_b;
    logic signed [63:0] fast_product;

    assign fast_a       = {signed_a_op(op_e) & operandA[31], operandA};
    assign fast_b       = {signed_b_op(op_e) & operandB[31], operandB};
    assign fast_product = 64'(fast_a) * 64'(fast_b);
    assign fast_mul     = ~is_div_op(op_e);
    assign fast_result  = (op_e == OpMul) ? fast_product[31:0] : fast_product[63:32];
`else
    assign fast_mul     = 1'b0;
    assign fast_result  = '0;
`endif

    always_comb begin
        special        = 1'b0;
        special_result = '0;
        if (is_div_op(op_e) && (operandB == 32'd0)) begin
            special        = 1'b1;
            special_result = (op_e inside {OpDiv, OpDivu}) ? DIV_ZERO_QUOTIENT : operandA;
        end else if ((op_e inside {OpDiv, OpRem}) && (operandA == 32'h80000000)
                     && (operandB == 32'hFFFFFFFF)) begin
            special        = 1'b1;
            special_result = (op_e == OpDiv) ? DIV_OVERFLOW_QUOTIENT : 32'd0;
        end else if (fast_mul) begin
            special        = 1'b1;
            special_result = fast_result;
        end
    end

    jzjpcc_muldiv_datapath u_datapath (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .op          (op_e),
        .operand_a   (operandA),
        .operand_b   (operandB),
        .step_result (step_result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush && start) begin
                    if (special) begin
                        state_d  = DONE;
                        result_d = special_result;
                    end else begin
                        state_d = RUN;
                        load    = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d  = DONE;
                        result_d = step_result;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign executeStall = ~reset & ~flush & (((state_q == IDLE) & start) | (state_q == RUN));
    assign resultValid  = (state_q == DONE) & ~flush;
    assign result       = result_q;

endmodule

// File: tb/tb_jzjpcc_muldiv_sequencer.sv
// Self-checking bench: per-cycle behavioural model plus directed literal vectors and random ops.
module tb_jzjpcc_muldiv_sequencer;

`ifdef JZJPCC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        flush;
    logic        executeStall;
    logic [31:0] result;
    logic        resultValid;

    int n_checks = 0;
    int n_fail   = 0;

    jzjpcc_muldiv_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .operandA     (operandA),
        .operandB     (operandB),
        .flush        (flush),
        .executeStall (executeStall),
        .result       (result),
        .resultValid  (resultValid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        if (!o[2]) return MUL_LAT;
        return 33;
    endfunction

    // Per-cycle model: k counts cycles since the op was accepted; stall for k < lat, valid at k == lat.
    bit          model_active = 0;
    int          model_k      = 0;
    int          model_lat    = 0;
    logic [31:0] model_res    = '0;
    logic [31:0] model_last   = '0;

    always @(negedge clock) begin
        logic        exp_valid;
        logic        exp_stall;
        logic [31:0] exp_res;
        if (reset) begin
            check("reset_stall", {31'd0, executeStall}, 32'd0);
            check("reset_valid", {31'd0, resultValid}, 32'd0);
            check("reset_result", result, 32'd0);
            model_active = 0;
            model_last   = '0;
        end else begin
            if (!model_active && start && !flush) begin
                model_active = 1;
                model_k      = 0;
                model_lat    = ref_latency(op, operandA, operandB);
                model_res    = ref_result(op, operandA, operandB);
            end
            exp_valid = model_active && !flush && (model_k == model_lat);
            exp_stall = model_active && !flush && (model_k < model_lat);
            exp_res   = exp_valid ? model_res : model_last;
            check("cyc_stall", {31'd0, executeStall}, {31'd0, exp_stall});
            check("cyc_valid", {31'd0, resultValid}, {31'd0, exp_valid});
            check("cyc_result", result, exp_res);
            if (model_active) begin
                if (flush) model_active = 0;
                else if (exp_valid) begin
                    model_active = 0;
                    model_last   = model_res;
                end else model_k++;
            end
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFFFFFF;
            3:       v = 32'h80000000;
            4:       v = $urandom_range(0, 20);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Issues one op and waits for resultValid; operands are scrambled while it runs.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int stalls);
        bit got;
        @(posedge clock);
        #1;
        flush    = 1'b0;
        start    = 1'b1;
        op       = o;
        operandA = a;
        operandB = b;
        stalls   = 0;
        got      = 0;
        r        = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (executeStall) stalls++;
            if (resultValid) begin
                got = 1;
                r   = result;
                break;
            end
            @(posedge clock);
            #1;
            op       = 3'($urandom_range(0, 7));
            operandA = $urandom();
            operandB = $urandom();
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: no resultValid within 100 cycles, op %0d", o);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] r;
        int          stalls;

        vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'd42,         MUL_LAT};
        vecs[1]  = '{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
        vecs[2]  = '{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
        vecs[3]  = '{3'd5, 32'd100,        32'd7,          32'd14,         33};
        vecs[4]  = '{3'd7, 32'd100,        32'd7,          32'd2,          33};
        vecs[5]  = '{3'd5, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
        vecs[6]  = '{3'd6, 32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        vecs[8]  = '{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
        vecs[9]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   MUL_LAT};
        vecs[10] = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          MUL_LAT};
        vecs[11] = '{3'd2, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   MUL_LAT};

        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = '0;
        operandA = '0;
        operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_stall", {31'd0, executeStall}, 32'd0);
        check("idle_result", result, 32'd0);

        // Directed vectors with hand-computed results; also pin the reference model.
        foreach (vecs[i]) begin
            check($sformatf("model_vec%0d", i), ref_result(vecs[i].op, vecs[i].a, vecs[i].b),
                  vecs[i].r);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, stalls);
            check($sformatf("vec%0d_result", i), r, vecs[i].r);
            check($sformatf("vec%0d_stalls", i), stalls, vecs[i].lat);
        end

        // Flush in cycle 10 of a DIV, then DIVU 9/3 immediately after.
        @(posedge clock);
        #1;
        start    = 1'b1;
        op       = 3'd4;
        operandA = 32'd1000;
        operandB = 32'd3;
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        @(negedge clock);
        check("flush_stall", {31'd0, executeStall}, 32'd0);
        check("flush_valid", {31'd0, resultValid}, 32'd0);
        check("flush_result", result, vecs[11].r);
        do_op(3'd5, 32'd9, 32'd3, r, stalls);
        check("post_flush_result", r, 32'd3);
        check("post_flush_stalls", stalls, 33);

        // Asynchronous reset in cycle 20 of a DIV.
        @(posedge clock);
        #1;
        start    = 1'b1;
        op       = 3'd4;
        operandA = 32'hFFFFFF9C;
        operandB = 32'd7;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b0;
        #1;
        check("async_rst_stall", {31'd0, executeStall}, 32'd0);
        check("async_rst_valid", {31'd0, resultValid}, 32'd0);
        check("async_rst_result", result, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        do_op(3'd7, 32'd9, 32'd4, r, stalls);
        check("post_rst_result", r, 32'd1);
        check("post_rst_stalls", stalls, 33);

        // Random ops, mostly back-to-back, checked against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            do_op(ro, ra, rb, r, stalls);
            check($sformatf("rand%0d_result", n), r, ref_result(ro, ra, rb));
            check($sformatf("rand%0d_stalls", n), stalls, ref_latency(ro, ra, rb));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
                start = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clock);
            end
        end

        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
